// File: rtl/reg_block_sequencer.sv
// Multi-cycle control sequencer for the mary/shelley/comp/ra register block, ALU, PC and memory.
// Control outputs are decoded from the current state and the opcode latched in DECODE.
module reg_block_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] instr,
  input  logic        comp_zero,
  output logic        ir_write,
  output logic        mdr_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_addr_src,
  output logic [1:0]  alu_op,
  output logic        mary_write,
  output logic        shelley_write,
  output logic        comp_write,
  output logic        ra_write,
  output logic [2:0]  mary_src,
  output logic [1:0]  shelley_src,
  output logic        ra_src,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  localparam logic [3:0] OP_LDM  = 4'h0;
  localparam logic [3:0] OP_LIM  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_CMP  = 4'h4;
  localparam logic [3:0] OP_MVS  = 4'h5;
  localparam logic [3:0] OP_MVM  = 4'h6;
  localparam logic [3:0] OP_LIS  = 4'h7;
  localparam logic [3:0] OP_LDS  = 4'h8;
  localparam logic [3:0] OP_JAL  = 4'h9;
  localparam logic [3:0] OP_LDRA = 4'hA;
  localparam logic [3:0] OP_STM  = 4'hB;
  localparam logic [3:0] OP_BEQZ = 4'hC;
  localparam logic [3:0] OP_ILLD = 4'hD;
  localparam logic [3:0] OP_ILLE = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t     state_r;
  state_t     state_next_s;
  state_t     end_next_s;
  logic [3:0] opcode_r;
  logic [3:0] dec_op_s;
  logic       illegal_r;
  logic       exec_illegal_s;

  assign dec_op_s       = instr[15:12];
  assign end_next_s     = run ? FETCH : IDLE;
  assign exec_illegal_s = (state_r == EXEC) && ((opcode_r == OP_ILLD) || (opcode_r == OP_ILLE));
  // illegal shows during the offending EXEC cycle and stays latched afterwards
  assign illegal        = illegal_r | exec_illegal_s;
  assign halted         = (state_r == HALT);

  // State, latched opcode and sticky illegal flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      opcode_r  <= 4'h0;
      illegal_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (state_r == DECODE) begin
        opcode_r <= dec_op_s;
      end
      if (exec_illegal_s) begin
        illegal_r <= 1'b1;
      end
    end
  end

  // Next-state and control decode
  always_comb begin
    state_next_s  = state_r;
    ir_write      = 1'b0;
    mdr_write     = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_addr_src  = 1'b0;
    alu_op        = 2'b00;
    mary_write    = 1'b0;
    shelley_write = 1'b0;
    comp_write    = 1'b0;
    ra_write      = 1'b0;
    mary_src      = 3'b000;
    shelley_src   = 2'b00;
    ra_src        = 1'b0;
    case (state_r)
      IDLE: begin
        if (run) begin
          state_next_s = FETCH;
        end else begin
          state_next_s = IDLE;
        end
      end
      FETCH: begin
        mem_read     = 1'b1;
        ir_write     = 1'b1;
        pc_write     = 1'b1;
        state_next_s = DECODE;
      end
      DECODE: begin
        case (dec_op_s)
          OP_LDM, OP_LDS, OP_LDRA, OP_STM: state_next_s = MEM;
          OP_HALT:                         state_next_s = HALT;
          default:                         state_next_s = EXEC;
        endcase
      end
      EXEC: begin
        state_next_s = end_next_s;
        case (opcode_r)
          OP_ADD: begin mary_write = 1'b1; mary_src = 3'b001; alu_op = 2'b00; end
          OP_SUB: begin mary_write = 1'b1; mary_src = 3'b001; alu_op = 2'b01; end
          OP_CMP: begin comp_write = 1'b1; alu_op = 2'b01; end
          OP_LIM: begin mary_write = 1'b1; mary_src = 3'b011; end
          OP_LIS: begin shelley_write = 1'b1; shelley_src = 2'b01; end
          OP_MVS: begin shelley_write = 1'b1; shelley_src = 2'b10; end
          OP_MVM: begin mary_write = 1'b1; mary_src = 3'b010; end
          OP_JAL: begin ra_write = 1'b1; ra_src = 1'b1; pc_write = 1'b1; pc_src = 1'b1; end
          OP_BEQZ: begin pc_write = comp_zero; pc_src = 1'b1; end
          default: begin end
        endcase
      end
      MEM: begin
        mem_addr_src = 1'b1;
        if (opcode_r == OP_STM) begin
          mem_write    = 1'b1;
          state_next_s = end_next_s;
        end else begin
          mem_read     = 1'b1;
          mdr_write    = 1'b1;
          state_next_s = WB;
        end
      end
      WB: begin
        state_next_s = end_next_s;
        case (opcode_r)
          OP_LDM:  mary_write    = 1'b1;
          OP_LDS:  shelley_write = 1'b1;
          OP_LDRA: ra_write      = 1'b1;
          default: begin end
        endcase
      end
      HALT: begin
        state_next_s = HALT;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_block_sequencer.sv
// Directed bench for reg_block_sequencer: a per-instruction cycle-plan model is compared every cycle,
// with literal cycle/flag expectations pinning the model.
module tb_reg_block_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        run;
  logic [15:0] instr;
  logic        comp_zero;
  logic        ir_write, mdr_write, pc_write, pc_src, mem_read, mem_write, mem_addr_src;
  logic [1:0]  alu_op;
  logic        mary_write, shelley_write, comp_write, ra_write;
  logic [2:0]  mary_src;
  logic [1:0]  shelley_src;
  logic        ra_src, halted, illegal;

  typedef struct packed {
    logic       ir_write;
    logic       mdr_write;
    logic       pc_write;
    logic       pc_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_addr_src;
    logic [1:0] alu_op;
    logic       mary_write;
    logic       shelley_write;
    logic       comp_write;
    logic       ra_write;
    logic [2:0] mary_src;
    logic [1:0] shelley_src;
    logic       ra_src;
    logic       halted;
    logic       illegal;
  } ctl_t;

  ctl_t act_s;
  assign act_s = {ir_write, mdr_write, pc_write, pc_src, mem_read, mem_write, mem_addr_src, alu_op,
                  mary_write, shelley_write, comp_write, ra_write, mary_src, shelley_src, ra_src,
                  halted, illegal};

  reg_block_sequencer dut (
    .clock(clock), .reset(reset), .run(run), .instr(instr), .comp_zero(comp_zero),
    .ir_write(ir_write), .mdr_write(mdr_write), .pc_write(pc_write), .pc_src(pc_src),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr_src(mem_addr_src), .alu_op(alu_op),
    .mary_write(mary_write), .shelley_write(shelley_write), .comp_write(comp_write),
    .ra_write(ra_write), .mary_src(mary_src), .shelley_src(shelley_src), .ra_src(ra_src),
    .halted(halted), .illegal(illegal)
  );

  always #5 clock = ~clock;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   ill_seen = 1'b0;
  ctl_t exp_q[$];
  int   mary_at[$];
  int   shelley_at[$];
  int   fetch_at[$];

  task automatic check(input string name, input ctl_t exp);
    checks++;
    if (act_s !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act_s, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic push(input ctl_t w);
    w.illegal = ill_seen;
    exp_q.push_back(w);
  endtask

  // Cycle-by-cycle control words one instruction must produce
  task automatic plan(input logic [3:0] op, input logic cz);
    ctl_t w;
    w = '0; w.mem_read = 1'b1; w.ir_write = 1'b1; w.pc_write = 1'b1;
    push(w);
    w = '0;
    push(w);
    w = '0;
    case (op)
      4'h0, 4'h8, 4'hA: begin
        w.mem_addr_src = 1'b1; w.mem_read = 1'b1; w.mdr_write = 1'b1;
        push(w);
        w = '0;
        if (op == 4'h0) w.mary_write = 1'b1;
        else if (op == 4'h8) w.shelley_write = 1'b1;
        else w.ra_write = 1'b1;
        push(w);
      end
      4'hB: begin w.mem_addr_src = 1'b1; w.mem_write = 1'b1; push(w); end
      4'h1: begin w.mary_write = 1'b1; w.mary_src = 3'd3; push(w); end
      4'h2: begin w.mary_write = 1'b1; w.mary_src = 3'd1; push(w); end
      4'h3: begin w.mary_write = 1'b1; w.mary_src = 3'd1; w.alu_op = 2'd1; push(w); end
      4'h4: begin w.comp_write = 1'b1; w.alu_op = 2'd1; push(w); end
      4'h5: begin w.shelley_write = 1'b1; w.shelley_src = 2'd2; push(w); end
      4'h6: begin w.mary_write = 1'b1; w.mary_src = 3'd2; push(w); end
      4'h7: begin w.shelley_write = 1'b1; w.shelley_src = 2'd1; push(w); end
      4'h9: begin w.ra_write = 1'b1; w.ra_src = 1'b1; w.pc_write = 1'b1; w.pc_src = 1'b1; push(w); end
      4'hC: begin w.pc_write = cz; w.pc_src = 1'b1; push(w); end
      4'hD, 4'hE: begin ill_seen = 1'b1; push(w); end
      default: begin
        w.halted = 1'b1;
        for (int i = 0; i < 3; i++) push(w);
      end
    endcase
  endtask

  // Run one instruction from the FETCH edge, checking every cycle against the plan
  task automatic run_instr(input logic [15:0] iw, input logic cz, input bit drop_run);
    ctl_t w;
    instr = iw;
    comp_zero = cz;
    plan(iw[15:12], cz);
    while (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      @(negedge clock);
      cyc++;
      check($sformatf("op%h", iw[15:12]), w);
      if (mary_write) mary_at.push_back(cyc);
      if (shelley_write) shelley_at.push_back(cyc);
      if (ir_write) fetch_at.push_back(cyc);
      if (drop_run) run = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    ctl_t w;
    reset = 1'b1; run = 1'b1; instr = 16'h0000; comp_zero = 1'b0;
    repeat (2) begin
      @(negedge clock);
      check("in_reset", '0);
    end
    reset = 1'b0;
    #1 check("idle_after_reset", '0);

    // LIM, LIS, ADD stream
    cyc = 0; mary_at.delete(); shelley_at.delete();
    run_instr(16'h1005, 1'b0, 1'b0);
    run_instr(16'h7003, 1'b0, 1'b0);
    run_instr(16'h2000, 1'b0, 1'b0);
    check_int("mary_count", mary_at.size(), 2);
    check_int("lim_cycle", mary_at[0], 3);
    check_int("lis_cycle", shelley_at[0], 6);
    check_int("add_cycle", mary_at[1], 9);

    // LDM then ADD: next FETCH at cycle 5
    cyc = 0; fetch_at.delete(); mary_at.delete();
    run_instr(16'h0010, 1'b0, 1'b0);
    run_instr(16'h2000, 1'b0, 1'b0);
    check_int("ldm_wb_cycle", mary_at[0], 4);
    check_int("ldm_next_fetch", fetch_at[1], 5);

    // CMP/BEQZ taken then not taken
    run_instr(16'h4000, 1'b0, 1'b0);
    run_instr(16'hC000, 1'b1, 1'b0);
    run_instr(16'h4000, 1'b0, 1'b0);
    run_instr(16'hC000, 1'b0, 1'b0);

    // JAL with run dropped mid-instruction: completes, then idles
    run_instr(16'h9020, 1'b0, 1'b1);
    repeat (2) begin
      @(negedge clock);
      check("idle_after_jal", '0);
    end
    run = 1'b1;

    run_instr(16'hB000, 1'b0, 1'b0);
    run_instr(16'h8000, 1'b0, 1'b0);
    run_instr(16'hA000, 1'b0, 1'b0);
    run_instr(16'h3000, 1'b0, 1'b0);
    run_instr(16'h5000, 1'b0, 1'b0);
    run_instr(16'h6000, 1'b0, 1'b0);

    // Reset during MEM of LDM: no WB afterwards
    instr = 16'h0010;
    plan(4'h0, 1'b0);
    repeat (3) begin
      w = exp_q.pop_front();
      @(negedge clock);
      check("ldm_pre_reset", w);
    end
    exp_q.delete();
    #2 reset = 1'b1;
    #1 check("reset_mid_mem", '0);
    run = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (2) begin
      @(negedge clock);
      check("no_wb_after_reset", '0);
    end
    run = 1'b1;

    // Illegal opcode is sticky, execution continues
    run_instr(16'hD000, 1'b0, 1'b0);
    run_instr(16'h2000, 1'b0, 1'b0);
    check_int("illegal_sticky", int'(illegal), 1);

    // HALT freezes until reset
    run_instr(16'hF000, 1'b0, 1'b0);
    check_int("halted_flag", int'(halted), 1);
    check_int("halt_no_fetch", int'(ir_write), 0);
    reset = 1'b1;
    #1 check("reset_from_halt", '0);
    check_int("halted_cleared", int'(halted), 0);
    check_int("illegal_cleared", int'(illegal), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
